// File: rtl/serial_frame_pkg.sv
// Shared definitions for the double-copy parity serial framing, used by the
// receiver and the matching transmitter.
package serial_frame_pkg;

  localparam int   DEFAULT_DATA_W = 8;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam logic IDLE_LVL       = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA0 = 3'd1,
    PAR0  = 3'd2,
    DATA1 = 3'd3,
    PAR1  = 3'd4,
    STOP  = 3'd5
  } state_t;

  // start + copy0 + parity0 + copy1 + parity1 + stop
  function automatic int frame_len(input int data_w);
    return 2 * data_w + 4;
  endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Line-side and result-side signals of the serial frame receiver.
interface serial_frame_rx_if
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);
  logic              ser_in;
  logic              bit_en;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_done;
  logic              err_parity;
  logic              err_copy;
  logic              err_frame;
  logic [3:0]        frame_cnt;

  modport master (
    output ser_in, bit_en,
    input  rx_data, rx_valid, rx_done, err_parity, err_copy, err_frame, frame_cnt
  );

  modport slave (
    input  ser_in, bit_en,
    output rx_data, rx_valid, rx_done, err_parity, err_copy, err_frame, frame_cnt
  );
endinterface

// File: rtl/frame_copy_shreg.sv
// One payload copy: MSB-first shift register with running even-parity XOR.
module frame_copy_shreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift,
  input  logic              din,
  output logic [DATA_W-1:0] q,
  output logic              par
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q   <= '0;
      par <= 1'b0;
    end else if (shift) begin
      q   <= {q[DATA_W-2:0], din};
      par <= par ^ din;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: deserialises two parity-protected copies of a payload,
// checks parity, copy agreement and stop bit, and reports one result per frame.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_frame_rx_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic              last_bit;
  logic              clr, shift0, shift1;
  logic [DATA_W-1:0] copy0, copy1;
  logic              par0, par1;
  logic              par_bad0, par_bad1, stop_bit, done_pend;
  logic              clean;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, rx_done;
  logic              err_parity, err_copy, err_frame;
  logic [3:0]        frame_cnt;

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  frame_copy_shreg #(.DATA_W(DATA_W)) u_copy0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .shift(shift0),
    .din(bus.ser_in), .q(copy0), .par(par0)
  );

  frame_copy_shreg #(.DATA_W(DATA_W)) u_copy1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .shift(shift1),
    .din(bus.ser_in), .q(copy1), .par(par1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Nothing advances without a strobe; every transition consumes one line bit.
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    shift0   = 1'b0;
    shift1   = 1'b0;
    if (bus.bit_en) begin
      case (state)
        IDLE:  if (bus.ser_in == START_BIT) begin
                 state_nx = DATA0;
                 clr      = 1'b1;
               end
        DATA0: begin
                 shift0 = 1'b1;
                 if (last_bit) state_nx = PAR0;
               end
        PAR0:  state_nx = DATA1;
        DATA1: begin
                 shift1 = 1'b1;
                 if (last_bit) state_nx = PAR1;
               end
        PAR1:  state_nx = STOP;
        STOP:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr)        bit_cnt <= '0;
    else if (shift0 || shift1) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
  end

  // Per-frame verdict bits, collected as the parity and stop slots go by.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_bad0  <= 1'b0;
      par_bad1  <= 1'b0;
      stop_bit  <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      done_pend <= 1'b0;
      if (bus.bit_en) begin
        case (state)
          PAR0: par_bad0 <= par0 ^ bus.ser_in;
          PAR1: par_bad1 <= par1 ^ bus.ser_in;
          STOP: begin
                  stop_bit  <= bus.ser_in;
                  done_pend <= 1'b1;
                end
          default: ;
        endcase
      end
    end
  end

  assign clean = !(par_bad0 || par_bad1) && (copy0 == copy1) && (stop_bit == STOP_BIT);

  // Result stage: copy registers still hold the finished frame here, because a
  // back-to-back start bit only clears them on this same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_done    <= 1'b0;
      err_parity <= 1'b0;
      err_copy   <= 1'b0;
      err_frame  <= 1'b0;
      frame_cnt  <= 4'd0;
    end else begin
      rx_done  <= done_pend;
      rx_valid <= 1'b0;
      if (done_pend) begin
        err_parity <= par_bad0 | par_bad1;
        err_copy   <= (copy0 != copy1);
        err_frame  <= (stop_bit != STOP_BIT);
        if (clean) begin
          rx_data   <= copy0;
          rx_valid  <= 1'b1;
          frame_cnt <= frame_cnt + 4'd1;
        end
      end
    end
  end

  assign bus.rx_data    = rx_data;
  assign bus.rx_valid   = rx_valid;
  assign bus.rx_done    = rx_done;
  assign bus.err_parity = err_parity;
  assign bus.err_copy   = err_copy;
  assign bus.err_frame  = err_frame;
  assign bus.frame_cnt  = frame_cnt;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomised bench for serial_frame_rx against a frame-level reference model.
module tb_serial_frame_rx;
  import serial_frame_pkg::*;

  localparam int DATA_W = DEFAULT_DATA_W;
  localparam int FLEN   = frame_len(DATA_W);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

  serial_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] m_data;
  logic [3:0]        m_cnt;
  logic              m_par, m_copy, m_frame, m_clean;
  bit                pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check just after posedge. The result of a
  // frame is due on the clock following the one that strobed its stop bit.
  task automatic tick(input logic en, input logic b, input logic rs);
    bit due;
    due  = pend && rs;
    pend = 1'b0;
    @(negedge clk);
    rst_n      = rs;
    bus.bit_en = en;
    bus.ser_in = b;
    @(posedge clk);
    #1;
    check("rx_done", 32'(bus.rx_done), 32'(due));
    check("rx_valid", 32'(bus.rx_valid), 32'(due && m_clean));
    if (due) begin
      check("rx_data", 32'(bus.rx_data), 32'(m_data));
      check("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
      check("err_parity", 32'(bus.err_parity), 32'(m_par));
      check("err_copy", 32'(bus.err_copy), 32'(m_copy));
      check("err_frame", 32'(bus.err_frame), 32'(m_frame));
    end
  endtask

  task automatic do_reset();
    tick(1'b0, IDLE_LVL, 1'b0);
    m_data = '0; m_cnt = '0; m_par = 0; m_copy = 0; m_frame = 0; m_clean = 0;
    pend = 1'b0;
    check("rst_data", 32'(bus.rx_data), 32'd0);
    check("rst_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_done", 32'(bus.rx_done), 32'd0);
    check("rst_par", 32'(bus.err_parity), 32'd0);
    check("rst_copy", 32'(bus.err_copy), 32'd0);
    check("rst_frame", 32'(bus.err_frame), 32'd0);
    check("rst_cnt", 32'(bus.frame_cnt), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, IDLE_LVL, 1'b1);
  endtask

  // Sends the first nbits of a frame; a complete frame updates the model.
  task automatic send_frame(input logic [DATA_W-1:0] d0, input logic p0,
                            input logic [DATA_W-1:0] d1, input logic p1,
                            input logic stp, input int maxgap, input int nbits);
    logic [FLEN-1:0] bits;
    int g;
    bits = {START_BIT, d0, p0, d1, p1, stp};
    for (int i = 0; i < nbits; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (g) tick(1'b0, 1'($urandom), 1'b1);
      tick(1'b1, bits[FLEN-1-i], 1'b1);
    end
    if (nbits == FLEN) begin
      m_par   = (($countones(d0) + int'(p0)) % 2 != 0) || (($countones(d1) + int'(p1)) % 2 != 0);
      m_copy  = (d0 != d1);
      m_frame = (stp == 1'b0);
      m_clean = !(m_par || m_copy || m_frame);
      if (m_clean) begin
        m_data = d0;
        m_cnt  = m_cnt + 4'd1;
      end
      pend = 1'b1;
    end
  endtask

  task automatic good_frame(input logic [DATA_W-1:0] d, input int maxgap);
    send_frame(d, ^d, d, ^d, 1'b1, maxgap, FLEN);
  endtask

  initial begin
    logic [DATA_W-1:0] d, d1;
    logic p0, p1, stp;
    int kind;
    bus.ser_in = IDLE_LVL;
    bus.bit_en = 1'b0;
    pend       = 1'b0;
    m_clean    = 1'b0;

    do_reset();

    good_frame(8'hA5, 0);
    idle(1);
    check("a5_data", 32'(bus.rx_data), 32'h0A5);
    check("a5_cnt", 32'(bus.frame_cnt), 32'd1);

    send_frame(8'hA5, 1'b1, 8'hA5, 1'b0, 1'b1, 0, FLEN);
    idle(1);
    check("par_err", 32'(bus.err_parity), 32'd1);
    check("par_keep", 32'(bus.rx_data), 32'h0A5);

    send_frame(8'h3C, 1'b0, 8'h3D, 1'b1, 1'b1, 0, FLEN);
    idle(1);
    check("copy_err", 32'(bus.err_copy), 32'd1);

    send_frame(8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0, 0, FLEN);
    good_frame(8'h11, 0);
    idle(1);
    check("b2b_data", 32'(bus.rx_data), 32'h011);
    check("b2b_frame", 32'(bus.err_frame), 32'd0);

    good_frame(8'hFF, 3);
    idle(1);
    check("gap_data", 32'(bus.rx_data), 32'h0FF);

    do_reset();
    for (int i = 0; i < 16; i++) good_frame(DATA_W'($urandom), 2);
    idle(1);
    check("cnt_wrap", 32'(bus.frame_cnt), 32'd0);

    do_reset();
    good_frame(8'h42, 0);
    send_frame(8'h81, 1'b0, 8'h81, 1'b0, 1'b1, 0, 10);
    do_reset();
    good_frame(8'h81, 0);
    idle(1);
    check("rst_mid_data", 32'(bus.rx_data), 32'h081);
    check("rst_mid_cnt", 32'(bus.frame_cnt), 32'd1);

    for (int n = 0; n < 40; n++) begin
      d    = DATA_W'($urandom);
      d1   = d;
      p0   = ^d;
      stp  = 1'b1;
      kind = int'($urandom_range(0, 3));
      case (kind)
        1: p0  = ~p0;
        2: d1  = d ^ (DATA_W'(1) << $urandom_range(0, DATA_W - 1));
        3: stp = 1'b0;
        default: ;
      endcase
      p1 = ^d1;
      send_frame(d, p0, d1, p1, stp, int'($urandom_range(0, 2)), FLEN);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
